// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one prescaled timebase.
// Duty and period registers are double-buffered; active copies load only at a
// period boundary so pulses are never truncated.
// Optional feature: define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter.
module pwm_multi #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRE_W    = 8,
    parameter int unsigned AW       = $clog2(CHANNELS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PRE_W-1:0]    prescale,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] PWM_sig,
    output logic                period_start,
    output logic [WIDTH-1:0]    cnt
);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    per_sh_q, per_sh_d;
    logic [WIDTH-1:0]    per_act_q, per_act_d;
    logic [WIDTH-1:0]    duty_sh_q [CHANNELS];
    logic [WIDTH-1:0]    duty_sh_d [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [WIDTH-1:0]    duty_act_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q, period_start_d;
    logic                tick;
    logic                boundary;

    // Prescaler: a tick every prescale+1 enabled cycles; >= catches a lowered prescale.
    always_comb begin
        tick      = en && (pre_cnt_q >= prescale);
        pre_cnt_d = pre_cnt_q;
        if (en) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_up_q, dir_up_d;

    // Up/down counter: 0..per_act, then per_act-1..1, boundary on the 1->0 tick.
    always_comb begin
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        boundary = 1'b0;
        if (tick) begin
            if (per_act_q == '0) begin
                boundary = 1'b1;
                cnt_d    = '0;
                dir_up_d = 1'b1;
            end else if (dir_up_q && (cnt_q != per_act_q)) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                // Descending, or turning around at the top.
                if (cnt_q <= WIDTH'(1)) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                    dir_up_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q - WIDTH'(1);
                    dir_up_d = 1'b0;
                end
            end
        end
    end

    // Direction flop for the center-aligned counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_up_q <= 1'b1;
        end else begin
            dir_up_q <= dir_up_d;
        end
    end
`else
    // Edge-aligned counter: 0..per_act, wrapping to 0 at the boundary.
    always_comb begin
        boundary = tick && (cnt_q == per_act_q);
        cnt_d    = cnt_q;
        if (tick) begin
            cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
        end
    end
`endif

    // Shadow writes, active reload at boundary, and output compare.
    always_comb begin
        per_sh_d       = per_sh_q;
        duty_sh_d      = duty_sh_q;
        per_act_d      = boundary ? per_sh_q : per_act_q;
        period_start_d = boundary;
        pwm_d          = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            duty_act_d[i] = boundary ? duty_sh_q[i] : duty_act_q[i];
            pwm_d[i]      = (cnt_q < duty_act_q[i]);
            if (wr_en && (wr_addr == AW'(i))) begin
                duty_sh_d[i] = wr_data;
            end
        end
        if (wr_en && (wr_addr == AW'(CHANNELS))) begin
            per_sh_d = wr_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            per_sh_q       <= '1;
            per_act_q      <= '1;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            per_sh_q       <= per_sh_d;
            per_act_q      <= per_act_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign PWM_sig      = pwm_q;
    assign period_start = period_start_q;
    assign cnt          = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi (default 8-bit, 4 channels).
// With PWM_CENTER_ALIGN_EN defined, runs the center-aligned sequence instead.
module tb_pwm_multi;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int PW  = 8;
    localparam int AWL = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic [PW-1:0] prescale;
    logic          wr_en;
    logic [AWL-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [CH-1:0] pwm_sig;
    logic          period_start;
    logic [W-1:0]  cnt;

    int            total;
    int            bad;
    int            hi [CH];
    int            ps_at;
    logic [W-1:0]  cnt_snap;
    logic [CH-1:0] pwm_snap;

    pwm_multi #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .PRE_W    (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .PWM_sig      (pwm_sig),
        .period_start (period_start),
        .cnt          (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write(input logic [AWL-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_ps(input int max_cyc, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < max_cyc);
        check(tag, 32'(period_start), 32'd1);
    endtask

    // Samples len cycles, counting high cycles per channel and the first period_start.
    task automatic run_period(input int len, input int wr_at, input logic [AWL-1:0] wa,
                              input logic [W-1:0] wd, input int en_off, input int en_on);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        ps_at = 0;
        for (int i = 1; i <= len; i++) begin
            step();
            wr_en = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (pwm_sig[c]) hi[c]++;
            end
            if (period_start && ps_at == 0) ps_at = i;
            if (i == en_off) en = 1'b0;
            if (i == en_on) begin
                cnt_snap = cnt;
                pwm_snap = pwm_sig;
                en       = 1'b1;
            end
            if (i == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
            end
        end
    endtask

    initial begin
        int cseq [8];
        int hsum;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        en       = 1'b1;
        prescale = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        cnt_snap = '0;
        pwm_snap = '0;
        step();
        step();
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_pwm", 32'(pwm_sig), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        rst = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
        write(3'd4, 8'd4);
        write(3'd0, 8'd2);
        wait_ps(1200, "ca_first_boundary");
        check("ca_cnt_at_start", 32'(cnt), 32'd0);
        cseq = '{1, 2, 3, 4, 3, 2, 1, 0};
        hsum = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (pwm_sig[0]) hsum++;
            check($sformatf("ca_cnt_%0d", k + 1), 32'(cnt), 32'(cseq[k]));
        end
        check("ca_high_ticks", 32'(hsum), 32'd3);
        check("ca_ps_on_return", 32'(period_start), 32'd1);
`else
        // Default period 255, duty ch0 = 64.
        write(3'd0, 8'd64);
        wait_ps(300, "t1_first_boundary");
        run_period(256, 0, '0, '0, 0, 0);
        check("t1_ch0_high", 32'(hi[0]), 32'd64);
        check("t1_others_high", 32'(hi[1] + hi[2] + hi[3]), 32'd0);
        check("t1_ps_at", 32'(ps_at), 32'd256);

        // Period 9, prescale 2, duties 0/5/10/3.
        prescale = 8'd2;
        write(3'd4, 8'd9);
        write(3'd0, 8'd0);
        write(3'd1, 8'd5);
        write(3'd2, 8'd10);
        write(3'd3, 8'd3);
        wait_ps(1000, "t2_first_boundary");
        run_period(30, 5, 3'd1, 8'd2, 0, 0);
        check("t2_ch0_high", 32'(hi[0]), 32'd0);
        check("t2_ch1_high", 32'(hi[1]), 32'd15);
        check("t2_ch2_high", 32'(hi[2]), 32'd30);
        check("t2_ch3_high", 32'(hi[3]), 32'd9);
        check("t2_ps_at", 32'(ps_at), 32'd30);

        // ch1 duty 2 active; mid-period write 7, then a write coincident with the boundary.
        run_period(30, 10, 3'd1, 8'd7, 0, 0);
        check("t3a_ch1_old_duty", 32'(hi[1]), 32'd6);
        check("t3a_ps_at", 32'(ps_at), 32'd30);
        run_period(30, 29, 3'd1, 8'd1, 0, 0);
        check("t3b_ch1_duty7", 32'(hi[1]), 32'd21);
        run_period(30, 0, '0, '0, 0, 0);
        check("t3c_ch1_still7", 32'(hi[1]), 32'd21);
        run_period(30, 0, '0, '0, 0, 0);
        check("t3d_ch1_duty1", 32'(hi[1]), 32'd3);
        check("t3d_ps_at", 32'(ps_at), 32'd30);

        // Hold en low for 13 cycles mid-period with a ch2 write during the hold.
        run_period(43, 15, 3'd2, 8'd4, 10, 23);
        check("t4_cnt_frozen", 32'(cnt_snap), 32'd3);
        check("t4_pwm_frozen", 32'(pwm_snap), 32'h4);
        check("t4_ps_late", 32'(ps_at), 32'd43);
        check("t4_ch2_high", 32'(hi[2]), 32'd43);
        check("t4_ch3_high", 32'(hi[3]), 32'd9);
        run_period(30, 5, 3'd0, 8'd8, 0, 0);
        check("t4_ch2_new_duty", 32'(hi[2]), 32'd12);
        check("t4_ps_at", 32'(ps_at), 32'd30);

        // Reset mid-period with cnt = 5 and ch0 high.
        repeat (16) step();
        check("t5_pre_cnt", 32'(cnt), 32'd5);
        check("t5_pre_ch0", 32'(pwm_sig[0]), 32'd1);
        rst      = 1'b1;
        prescale = 8'd0;
        step();
        check("t5_rst_cnt", 32'(cnt), 32'd0);
        check("t5_rst_pwm", 32'(pwm_sig), 32'd0);
        check("t5_rst_ps", 32'(period_start), 32'd0);
        rst = 1'b0;
        run_period(256, 0, '0, '0, 0, 0);
        check("t5_period_255", 32'(ps_at), 32'd256);
        check("t5_duties_zero", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator that replaces the single fixed 8-bit PWM. All channels share one timebase: a prescaler and a counter with a programmable period. Each channel has its own double-buffered duty register. The block sits between the register/control logic and the motor/LED drive pins. Writes to duty and period take effect only at a period boundary, so no glitched or truncated pulses are produced.

## Interface
- WIDTH, 8: counter, period and duty width.
- CHANNELS, 4: number of PWM outputs.
- PRE_W, 8: prescaler width.
- AW, $clog2(CHANNELS)+1: write address width (derived).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  timebase enable; 0 freezes prescaler and counter.
- prescale  in  PRE_W  tick divider, sampled live; one counter tick every prescale+1 clk cycles.
- wr_en  in  1  write strobe, one cycle.
- wr_addr  in  AW  0..CHANNELS-1 selects a duty shadow; CHANNELS selects the period shadow; other values are ignored.
- wr_data  in  WIDTH  write value.
- PWM_sig  out  CHANNELS  registered PWM outputs, bit n = channel n.
- period_start  out  1  one-cycle pulse when a new period begins.
- cnt  out  WIDTH  current counter value, for debug and sync.

## Operation
- Reset values:
  - prescaler count and counter: 0.
  - all duty shadow/active registers: 0.
  - period shadow/active: all ones (2^WIDTH-1).
  - PWM_sig: 0.
  - period_start: 0.
  - count direction: up.
- Prescaler: pre_cnt increments each cycle while en=1. When pre_cnt >= prescale, a tick fires and pre_cnt returns to 0. If prescale is lowered below pre_cnt, a tick fires on the next enabled cycle.
- Counter (edge-aligned) advances on tick: 0,1,…,per_act, then back to 0.
- Boundary event: a tick while cnt==per_act. On this event:
  - cnt <= 0.
  - every duty_act <= duty_sh.
  - per_act <= per_sh.
  - period_start <= 1 for that one cycle.
- Writes: wr_en loads the addressed shadow register at the clock edge. Active registers change only at a boundary event.
  - A write coincident with a boundary lands in the shadow only. The active register takes the old shadow value, and the new value applies one period later.
- Output compare: each cycle, PWM_sig[n] <= (cnt < duty_act[n]), using current register values.
  - duty 0: constantly low.
  - duty > per_act: constantly high.
  - Compare is unsigned, full WIDTH bits; no overflow possible.
- per_act = 0: cnt stays 0 and every tick is a boundary event.
- en = 0:
  - pre_cnt and cnt hold; no ticks and no boundary events.
  - PWM_sig continues to reflect the held cnt.
  - Shadow writes are still accepted.
- rst mid-period returns everything to reset values on the next edge. No partial period completes.

## Timing
- PWM_sig lags cnt by exactly one clk cycle.
- period_start is asserted in the cycle when cnt first shows 0 of the new period.
- Edge-aligned period = (per_act+1)*(prescale+1) clk cycles. High time = min(duty, per_act+1)*(prescale+1) clk cycles.
- Write-to-effect latency: takes effect at the next boundary event, which may be up to a full period away.
- Outputs are free of glitches: all outputs are flops.

## Configuration
- PWM_CENTER_ALIGN_EN defined:
  - Counter runs up 0..per_act, then down per_act-1..1, then 0. A period is 2*per_act ticks.
  - The boundary event is the tick where cnt goes 1->0, or every tick when per_act=0.
  - High time = (2*duty-1) ticks for 1 <= duty <= per_act; duty 0 is constantly low; duty > per_act is constantly high.
  - Direction flips on the tick after reaching per_act, and again at 0.
- PWM_CENTER_ALIGN_EN undefined: edge-aligned only, with no direction flop.

## Test plan
- Reset, prescale=0, default period 255, write duty ch0=64: after the first boundary, ch0 is high 64 of every 256 cycles; other channels stay at 0.
- Period=9, prescale=2, duties 0/5/10/3: period_start every 30 cycles; channels high for 0/15/30/9 cycles.
- Write ch1 duty 2->7 mid-period, and again in the exact boundary cycle: the old duty is kept until the boundary. The coincident write appears one period later.
- Drop en for 13 cycles mid-period: cnt and PWM_sig are frozen; the period completes late by exactly 13 cycles; a write during the hold is applied at the next boundary.
- Assert rst with cnt=5 and ch0 high: on the next edge, PWM_sig=0, cnt=0, period=255, duties=0.
- With PWM_CENTER_ALIGN_EN, period=4, duty=2: cnt sequence 0,1,2,3,4,3,2,1; output high 3 of every 8 ticks; period_start on each return to 0.
